mem_access_stage: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline register in the 5-stage CPU.
- Turns MEMMemRead/MEMMemWrite into a req/ack transaction on the data-memory bus.
- Stalls the upstream pipeline until the access completes, then loads the MEM/WB register.
- The WB mux and register file read the WB* outputs.

---
 rtl/mem_access_stage.sv | 146 ++++++++++++++
 tb/tb_mem_access_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage controller between the EX/MEM and MEM/WB registers.
// It turns loads and stores into a req/ack transaction on the data-memory bus
// and stalls the upstream pipeline until the transaction completes.
// Optional build macro MEM_TIMEOUT_EN adds an ACCESS watchdog with a sticky mem_err.
module mem_access_stage #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  MEMrd,
  input  logic [31:0] MEMPC,
  input  logic [31:0] MEMALUOut,
  input  logic [31:0] MEMDatabus3,
  input  logic        MEMRegWrite,
  input  logic        MEMMemRead,
  input  logic        MEMMemWrite,
  input  logic [1:0]  MEMMemtoReg,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        stall,
  output logic [4:0]  WBrd,
  output logic [31:0] WBPC,
  output logic [31:0] WBALUOut,
  output logic [31:0] WBMemData,
  output logic        WBRegWrite,
  output logic [1:0]  WBMemtoReg,
  output logic        mem_err
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t state, state_nx;
  logic   acc;
  logic   cap_req;    // latch the bus request fields and enter ACCESS
  logic   wb_load;    // MEM/WB takes the MEM-stage instruction
  logic   wb_bubble;  // MEM/WB takes a bubble while the access is pending
  logic   rd_cap;     // completing a read: capture mem_rdata
  logic   timeout;    // watchdog expiry this cycle (never set without the watchdog)

  // A store wins when both read and write are flagged, because mem_we follows MEMMemWrite.
  assign acc     = MEMMemRead | MEMMemWrite;
  assign mem_req = (state == ACCESS);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state, stall and MEM/WB load controls
  always_comb begin
    state_nx  = state;
    stall     = 1'b0;
    cap_req   = 1'b0;
    wb_load   = 1'b0;
    wb_bubble = 1'b0;
    rd_cap    = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          stall     = 1'b1;
          cap_req   = 1'b1;
          wb_bubble = 1'b1;
          state_nx  = ACCESS;
        end else begin
          wb_load = 1'b1;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          wb_load  = 1'b1;
          rd_cap   = ~mem_we;
          state_nx = IDLE;
        end else if (timeout) begin
          wb_load  = 1'b1;
          state_nx = IDLE;
        end else begin
          stall     = 1'b1;
          wb_bubble = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Bus request fields and MEM/WB register; fields hold stable for the whole ACCESS window
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      WBrd       <= '0;
      WBPC       <= '0;
      WBALUOut   <= '0;
      WBMemData  <= '0;
      WBRegWrite <= 1'b0;
      WBMemtoReg <= '0;
    end else begin
      if (cap_req) begin
        mem_addr  <= MEMALUOut;
        mem_wdata <= MEMDatabus3;
        mem_we    <= MEMMemWrite;
      end
      if (wb_load) begin
        WBrd       <= MEMrd;
        WBPC       <= MEMPC;
        WBALUOut   <= MEMALUOut;
        WBRegWrite <= MEMRegWrite & ~timeout;
        WBMemtoReg <= MEMMemtoReg;
      end else if (wb_bubble) begin
        WBrd       <= '0;
        WBRegWrite <= 1'b0;
      end
      if (rd_cap) WBMemData <= mem_rdata;
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  assign timeout = (state == ACCESS) && !mem_ack && (to_cnt == TO_W'(TIMEOUT));

  // Watchdog counter and sticky error; a timed-out instruction retires without writing back
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt  <= '0;
      mem_err <= 1'b0;
    end else begin
      if (cap_req)
        to_cnt <= '0;
      else if ((state == ACCESS) && !mem_ack && !timeout)
        to_cnt <= to_cnt + TO_W'(1);
      if (timeout) mem_err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: transaction-level reference model,
// per-cycle compare process, directed scenarios and randomized instruction stream.
module tb_mem_access_stage;

`ifdef MEM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  MEMrd;
  logic [31:0] MEMPC, MEMALUOut, MEMDatabus3;
  logic        MEMRegWrite, MEMMemRead, MEMMemWrite;
  logic [1:0]  MEMMemtoReg;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_req, mem_we, stall, WBRegWrite, mem_err;
  logic [31:0] mem_addr, mem_wdata, WBPC, WBALUOut, WBMemData;
  logic [4:0]  WBrd;
  logic [1:0]  WBMemtoReg;

  mem_access_stage #(.TIMEOUT(TMO), .TO_W(8)) dut (
    .clk(clk), .reset(reset),
    .MEMrd(MEMrd), .MEMPC(MEMPC), .MEMALUOut(MEMALUOut), .MEMDatabus3(MEMDatabus3),
    .MEMRegWrite(MEMRegWrite), .MEMMemRead(MEMMemRead), .MEMMemWrite(MEMMemWrite),
    .MEMMemtoReg(MEMMemtoReg), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall(stall), .WBrd(WBrd), .WBPC(WBPC), .WBALUOut(WBALUOut), .WBMemData(WBMemData),
    .WBRegWrite(WBRegWrite), .WBMemtoReg(WBMemtoReg), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] pc, alu, d3;
    logic        rw, mr, mw;
    logic [1:0]  m2r;
  } ins_t;

  // Reference model state: what each output must be in the current cycle
  logic        e_req, e_stall, m_we, m_err, wb_rw;
  logic [31:0] m_addr, m_wdata, wb_pc, wb_alu, wb_md;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_m2r;
  logic        chk_en = 1'b0;

  int n_chk = 0, n_fail = 0;
  int stall_cnt = 0, req_cnt = 0, win_cnt = 0;
  logic        prev_req = 1'b0, last_we = 1'b0;
  logic [31:0] last_addr = 0, last_wdata = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_req",    32'(mem_req),    32'(e_req));
      chk("stall",      32'(stall),      32'(e_stall));
      chk("mem_we",     32'(mem_we),     32'(m_we));
      chk("mem_addr",   mem_addr,        m_addr);
      chk("mem_wdata",  mem_wdata,       m_wdata);
      chk("WBrd",       32'(WBrd),       32'(wb_rd));
      chk("WBPC",       WBPC,            wb_pc);
      chk("WBALUOut",   WBALUOut,        wb_alu);
      chk("WBMemData",  WBMemData,       wb_md);
      chk("WBRegWrite", 32'(WBRegWrite), 32'(wb_rw));
      chk("WBMemtoReg", 32'(WBMemtoReg), 32'(wb_m2r));
      chk("mem_err",    32'(mem_err),    32'(m_err));
      if (stall) stall_cnt++;
      if (mem_req) begin
        req_cnt++;
        last_we = mem_we; last_addr = mem_addr; last_wdata = mem_wdata;
      end
      if (mem_req && !prev_req) win_cnt++;
      prev_req = mem_req;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end of test, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input ins_t i);
    MEMrd = i.rd; MEMPC = i.pc; MEMALUOut = i.alu; MEMDatabus3 = i.d3;
    MEMRegWrite = i.rw; MEMMemRead = i.mr; MEMMemWrite = i.mw; MEMMemtoReg = i.m2r;
  endtask

  task automatic wb_take(input ins_t i, input logic kill);
    wb_rd = i.rd; wb_pc = i.pc; wb_alu = i.alu; wb_rw = i.rw & ~kill; wb_m2r = i.m2r;
  endtask

  task automatic wb_bubble();
    wb_rd = 5'd0; wb_rw = 1'b0;
  endtask

  task automatic model_zero();
    m_we = 0; m_addr = 0; m_wdata = 0; m_err = 0;
    wb_rd = 0; wb_pc = 0; wb_alu = 0; wb_md = 0; wb_rw = 0; wb_m2r = 0;
  endtask

  function automatic ins_t mk(input logic [4:0] rd, input logic [31:0] pc, alu, d3,
                              input logic rw, mr, mw, input logic [1:0] m2r);
    ins_t i;
    i.rd = rd; i.pc = pc; i.alu = alu; i.d3 = d3; i.rw = rw; i.mr = mr; i.mw = mw; i.m2r = m2r;
    return i;
  endfunction

  // One instruction held in EX/MEM until it retires. dly = ACCESS cycle carrying the ack
  // (1 = first ACCESS cycle); 0 = no ack at all (only meaningful with the watchdog).
  task automatic run_instr(input ins_t i, input int dly, input logic [31:0] adat);
    logic acc, ak, to;
    logic [31:0] rdv;
    acc = i.mr | i.mw;
    drive(i);
    mem_ack = 1'($urandom);        // stray ack / data while idle must be ignored
    mem_rdata = $urandom;
    e_req = 1'b0; e_stall = acc;
    tick();
    if (!acc) begin
      wb_take(i, 1'b0);
      return;
    end
    m_addr = i.alu; m_wdata = i.d3; m_we = i.mw;
    wb_bubble();
    for (int k = 1; k <= 64; k++) begin
      ak = (k == dly);
      to = TMO_EN && !ak && (k == TMO + 1);
      rdv = ak ? adat : $urandom;
      mem_ack = ak; mem_rdata = rdv;
      e_req = 1'b1; e_stall = !ak && !to;
      tick();
      if (ak) begin
        wb_take(i, 1'b0);
        if (!i.mw) wb_md = rdv;
        break;
      end
      if (to) begin
        wb_take(i, 1'b1);
        m_err = 1'b1;
        break;
      end
      wb_bubble();
    end
    mem_ack = 1'b0;
  endtask

  task automatic clr_cnt();
    stall_cnt = 0; req_cnt = 0; win_cnt = 0;
  endtask

  initial begin
    ins_t ri, i2;
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    mem_ack = 1'b0; mem_rdata = 0;
    model_zero();
    e_req = 0; e_stall = 0;
    tick(); tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;

    // ALU instruction: one cycle, no request
    clr_cnt();
    run_instr(mk(5'd5, 32'h100, 32'h1234, 32'h0, 1, 0, 0, 2'd0), 1, 0);
    chk("alu_WBrd", 32'(WBrd), 32'd5);
    chk("alu_WBALUOut", WBALUOut, 32'h1234);
    chk("alu_WBRegWrite", 32'(WBRegWrite), 32'd1);
    chk("alu_req_cycles", req_cnt, 0);
    chk("alu_stall_cycles", stall_cnt, 0);

    // Load, ack three cycles after the request rises
    clr_cnt();
    run_instr(mk(5'd7, 32'h104, 32'h40, 32'h0, 1, 1, 0, 2'd1), 4, 32'hDEADBEEF);
    chk("ld_WBMemData", WBMemData, 32'hDEADBEEF);
    chk("ld_WBRegWrite", 32'(WBRegWrite), 32'd1);
    chk("ld_stall_cycles", stall_cnt, 4);
    chk("ld_req_cycles", req_cnt, 4);
    chk("ld_addr", last_addr, 32'h40);
    chk("ld_we", 32'(last_we), 32'd0);

    // Store acked on the first ACCESS cycle
    clr_cnt();
    run_instr(mk(5'd0, 32'h108, 32'h80, 32'hA5A5A5A5, 0, 0, 1, 2'd0), 1, 32'h12345678);
    chk("st_stall_cycles", stall_cnt, 1);
    chk("st_req_cycles", req_cnt, 1);
    chk("st_we", 32'(last_we), 32'd1);
    chk("st_wdata", last_wdata, 32'hA5A5A5A5);
    chk("st_addr", last_addr, 32'h80);
    chk("st_WBMemData_held", WBMemData, 32'hDEADBEEF);

    // Back-to-back load then store: two windows separated by one idle request cycle
    clr_cnt();
    run_instr(mk(5'd9, 32'h10C, 32'h200, 32'h0, 1, 1, 0, 2'd1), 2, 32'hCAFEF00D);
    chk("b2b_ld_addr", last_addr, 32'h200);
    run_instr(mk(5'd0, 32'h110, 32'h204, 32'h0BADF00D, 0, 0, 1, 2'd0), 1, 0);
    chk("b2b_st_addr", last_addr, 32'h204);
    chk("b2b_st_wdata", last_wdata, 32'h0BADF00D);
    chk("b2b_windows", win_cnt, 2);
    chk("b2b_req_cycles", req_cnt, 3);
    chk("b2b_WBMemData", WBMemData, 32'hCAFEF00D);

`ifdef MEM_TIMEOUT_EN
    // Load never acked: watchdog retires it without a register write
    clr_cnt();
    run_instr(mk(5'd3, 32'h114, 32'h300, 32'h0, 1, 1, 0, 2'd1), 0, 0);
    chk("to_req_cycles", req_cnt, TMO + 1);
    chk("to_mem_err", 32'(mem_err), 32'd1);
    chk("to_WBRegWrite", 32'(WBRegWrite), 32'd0);
    run_instr(mk(5'd4, 32'h118, 32'h55, 32'h0, 1, 0, 0, 2'd0), 1, 0);
    chk("to_next_WBRegWrite", 32'(WBRegWrite), 32'd1);
    chk("to_next_WBALUOut", WBALUOut, 32'h55);
    chk("to_err_sticky", 32'(mem_err), 32'd1);
`endif

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      ri = mk(5'($urandom), $urandom, $urandom, $urandom,
              1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
      run_instr(ri, int'($urandom_range(1, 6)), $urandom);
    end

    // Reset two cycles into ACCESS abandons the request
    ri = mk(5'd11, 32'h200, 32'h400, 32'h0, 1, 1, 0, 2'd1);
    drive(ri);
    mem_ack = 1'b0;
    e_req = 1'b0; e_stall = 1'b1;
    tick();
    m_addr = ri.alu; m_wdata = ri.d3; m_we = ri.mw;
    wb_bubble();
    for (int k = 0; k < 2; k++) begin
      e_req = 1'b1; e_stall = 1'b1;
      tick();
      wb_bubble();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_zero();
    i2 = mk(5'd12, 32'h300, 32'h777, 32'h0, 1, 0, 0, 2'd2);
    drive(i2);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
    e_req = 1'b0; e_stall = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_WBPC", WBPC, 32'd0);
    chk("rst_WBRegWrite", 32'(WBRegWrite), 32'd0);
    chk("rst_WBMemData", WBMemData, 32'd0);
    tick();
    wb_take(i2, 1'b0);
    mem_ack = 1'b0;
    chk("rst_stray_ack_WBMemData", WBMemData, 32'd0);
    chk("rst_after_WBALUOut", WBALUOut, 32'h777);
    e_req = 1'b0; e_stall = 1'b0;
    @(negedge clk); #1;
    chk_en = 1'b0;
    chk("rst_stray_ack_req", 32'(mem_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
